// File: rtl/rr_arb4_sel.sv
// rr_arb4_sel: round-robin arbiter for 4 requesters driving a 2-to-4 decoder select/enable pair
module rr_arb4_sel #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_en,
  output logic       timeout
);
  localparam int CW = $clog2(HOLD_MAX);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    win;
  logic [CW-1:0] cnt;
  logic          expire;
  logic          rel;
  // first requester at or after ptr, scanning downward so the nearest one wins
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
  end
  assign expire = cnt == CW'(HOLD_MAX - 1);
  assign rel    = done || !req[gnt_idx] || expire;
  // arbitration state, hold counter, priority pointer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt_idx <= '0;
      gnt_en  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          gnt_idx <= win;
          gnt_en  <= 1'b1;
          cnt     <= '0;
          state   <= GRANT;
        end
      end else if (rel) begin
        gnt_en  <= 1'b0;
        state   <= IDLE;
        ptr     <= gnt_idx + 2'd1;
        timeout <= expire && !done && req[gnt_idx];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
